// File: rtl/ring_counter_n.sv
// ring_counter_n
//   Parametrised ring (one-hot) / Johnson (twisted-ring) counter with runtime
//   mode select, up/down direction, count enable, synchronous parallel load
//   and illegal-state detection with optional self-correction.
//
// Parameters
//   WIDTH        number of stages (>= 2)
//   AUTO_CORRECT 1: an illegal state/load is replaced by the mode seed
//                0: an illegal state/load is kept and only flagged
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       synchronous reset, active-high (ring mode, q_o = seed 0..01)
//   en_i        advance one step
//   dir_i       0 = rotate toward MSB, 1 = rotate toward LSB
//   mode_i      0 = ring, 1 = Johnson
//   load_i      synchronous parallel load of load_val_i in mode mode_i
//   load_val_i  value to load
//   q_o         counter state (registered)
//   wrap_o      one-cycle pulse: a step has just re-entered the seed
//   err_o       one-cycle pulse: illegal state or illegal load seen
module ring_counter_n #(
  parameter int WIDTH        = 4,
  parameter bit AUTO_CORRECT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] RING_SEED    = WIDTH'(1);
  localparam logic [WIDTH-1:0] JOHNSON_SEED = '0;

  logic             mode_q;
  logic [WIDTH-1:0] q_nxt;
  logic             mode_nxt;
  logic             wrap_nxt;
  logic             err_nxt;
  logic             state_ok;
  logic             load_ok;
  logic [WIDTH-1:0] step_val;

  function automatic logic [WIDTH-1:0] seed_of(input logic m);
    return m ? JOHNSON_SEED : RING_SEED;
  endfunction

  // Ring: exactly one bit set. Johnson: at most one change between adjacent
  // bits scanning bit0..bit WIDTH-1 without wrap-around.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    int unsigned ones;
    int unsigned edges;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) ones++;
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (v[i] != v[i+1]) edges++;
    end
    return m ? (edges <= 1) : (ones == 1);
  endfunction

  // The bit re-entering at the far end is inverted in Johnson mode.
  function automatic logic [WIDTH-1:0] step_of(input logic [WIDTH-1:0] v,
                                               input logic m,
                                               input logic d);
    logic [WIDTH-1:0] r;
    if (!d) r = {v[WIDTH-2:0], v[WIDTH-1] ^ m};
    else    r = {v[0] ^ m, v[WIDTH-1:1]};
    return r;
  endfunction

  always_comb begin
    state_ok = is_legal(q_o, mode_q);
    load_ok  = is_legal(load_val_i, mode_i);
    step_val = step_of(q_o, mode_q, dir_i);
  end

  always_comb begin
    q_nxt    = q_o;
    mode_nxt = mode_q;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (load_i) begin
      // A load never reports wrap, even when it lands on the seed.
      mode_nxt = mode_i;
      if (load_ok) begin
        q_nxt = load_val_i;
      end else begin
        err_nxt = 1'b1;
        q_nxt   = AUTO_CORRECT ? seed_of(mode_i) : load_val_i;
      end
    end else if (mode_i != mode_q) begin
      q_nxt    = seed_of(mode_i);
      mode_nxt = mode_i;
      err_nxt  = ~state_ok;
    end else if (!state_ok && AUTO_CORRECT) begin
      q_nxt   = seed_of(mode_q);
      err_nxt = 1'b1;
    end else begin
      // Without auto-correction an illegal state keeps stepping but is
      // flagged every cycle it persists.
      err_nxt = ~state_ok;
      if (en_i) begin
        q_nxt    = step_val;
        wrap_nxt = (step_val == seed_of(mode_q));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o    <= RING_SEED;
      mode_q <= 1'b0;
      wrap_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      q_o    <= q_nxt;
      mode_q <= mode_nxt;
      wrap_o <= wrap_nxt;
      err_o  <= err_nxt;
    end
  end

endmodule

// File: doc/ring_counter_n.md
Name: ring_counter_n

Overview:
Parametrised ring/Johnson counter. It is the successor to the discrete D-flip-flop ring counter and generalises it to WIDTH stages. Adds runtime mode select (ring or twisted-ring/Johnson), up/down direction, count enable and synchronous parallel load. Detects and self-corrects illegal states. Used as a one-hot/thermometer sequencer and phase generator for FPGA demo designs.

Parameters:
WIDTH, 4, number of stages (legal range >= 2)
AUTO_CORRECT, 1, 1 = an illegal state is replaced by the mode seed; 0 = an illegal state is kept and only flagged

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous reset, active-high
en_i  input  1  advance one step on this edge
dir_i  input  1  0 = up (rotate toward MSB), 1 = down (rotate toward LSB)
mode_i  input  1  0 = ring (one-hot), 1 = Johnson
load_i  input  1  synchronous parallel load
load_val_i  input  WIDTH  value to load
q_o  output  WIDTH  counter state (registered)
wrap_o  output  1  one-cycle pulse: a step has just re-entered the seed
err_o  output  1  one-cycle pulse: an illegal state or illegal load was seen

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Seeds: ring seed = 1 in bit0, zeros elsewhere (WIDTH=4: 0001). Johnson seed = all zeros.
- Legality:
  - Ring: exactly one bit set.
  - Johnson: at most one change between adjacent bits, scanning linearly from bit0 to bit WIDTH-1 (no wrap-around) — 2*WIDTH legal patterns.
- Internal mode_q register holds the active mode.
- Reset (rst_i=1 at the edge): q_o = 0001 (ring seed), mode_q = 0, wrap_o = 0, err_o = 0. Reset overrides every other input.
- Priority per edge: rst_i > load_i > mode change (mode_i != mode_q) > illegal-state correction > en_i step > hold.
- Load:
  - Legal load_val_i for mode_i: q_o = load_val_i and mode_q = mode_i on the next edge. Latency 1.
  - Illegal load_val_i: err_o = 1 for one cycle. With AUTO_CORRECT=1, q_o = seed(mode_i); with AUTO_CORRECT=0, q_o = load_val_i.
  - A load never asserts wrap_o, even when the loaded value equals the seed.
- Mode change (no load pending): q_o = seed(new mode) and mode_q = mode_i. The en_i step is suppressed that cycle. wrap_o = 0.
- Correction:
  - The current q_o is checked every cycle against mode_q, regardless of en_i.
  - Illegal with AUTO_CORRECT=1: next q_o = seed, err_o = 1, and the step is suppressed.
  - Illegal with AUTO_CORRECT=0: err_o = 1 and stepping proceeds normally.
- Step rules (en_i=1, state legal):
  - Ring up: q <= {q[W-2:0], q[W-1]}.
  - Ring down: q <= {q[0], q[W-1:1]}.
  - Johnson up: q <= {q[W-2:0], ~q[W-1]}.
  - Johnson down: q <= {~q[0], q[W-1:1]}.
- Periods: ring = WIDTH steps, Johnson = 2*WIDTH steps, in either direction.
- wrap_o: registered. It is 1 in the same cycle that q_o first shows the seed as the result of an en_i step. Otherwise 0.
- en_i=0: q_o holds. wrap_o = 0. err_o still reports illegal states.
- Changing dir_i takes effect on the next step. There is no penalty cycle and no reseed.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
1. Ring up, WIDTH=4: reset, then en_i=1, dir_i=0 for 4 cycles -> q_o sequence 0001, 0010, 0100, 1000, 0001; wrap_o=1 only with the final 0001.
2. Johnson up: set mode_i=1 (q_o -> 0000 after one edge, wrap_o=0), then step 8 times -> q_o sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap_o=1 on the final 0000. Then dir_i=1 for one step -> q_o=1000.
3. Ring down: from 0001 with dir_i=1 -> q_o sequence 1000, 0100, 0010, 0001; wrap_o pulses on the return to 0001. Then en_i=0 for 3 cycles -> q_o stays 0001, wrap_o stays 0.
4. Illegal load, ring mode: load_val_i=0101 -> q_o=0001 and err_o=1 for one cycle (AUTO_CORRECT=1). With AUTO_CORRECT=0 -> q_o=0101, err_o=1, then err_o stays 1 on each following cycle while the state is illegal.
5. Legal load, Johnson mode: load_val_i=1100 -> q_o=1100, err_o=0. Next up step -> 1000. Loading 0000 -> wrap_o stays 0.
6. Priority: rst_i=1 together with load_i=1 and en_i=1 mid-sequence -> q_o=0001, mode_q=0, wrap_o=0, err_o=0. load_i and en_i together -> the load wins and no step occurs.
